leaf_uart_boot_loader: RTL
==========================

// Module: leaf_uart_boot_loader
// PURPOSE
//  Receives the serial boot stream on the chip UART RX pin and writes the program into Leaf instruction memory.
//  Frame format: LOAD_CMD (0x77), then a 1-byte program size in bytes, then the program bytes, each word LSB first.
//  The block holds the Leaf core in reset while loading and releases it once the last word is written.
//  It sits between the mprj_io[0] RX pad and the core's memory write port.
// PARAMETERS
//  BAUD_DIV   434    clocks per UART bit (8N1, LSB first)
//  ADDR_W     8      memory word-address width
//  BASE_ADDR  0      word address of the first program word
//  LOAD_CMD   8'h77  command byte that starts a load
// PORTS
//  wb_clk_i     in   1       system clock
//  wb_rst_i     in   1       reset, asynchronous, active-high
//  rx_i         in   1       UART RX line, asynchronous to the clock, idle high
//  mem_addr_o   out  ADDR_W  word address of the write
//  mem_wdata_o  out  32      write data
//  mem_we_o     out  1       write request, held until mem_ack_i
//  mem_ack_i    in   1       write accepted (single-cycle pulse)
//  core_rst_o   out  1       Leaf core reset, active-high
//  busy_o       out  1       load in progress (state SIZE, DATA or WRITE)
//  done_o       out  1       one-cycle pulse when a load completes
//  err_o        out  1       sticky error flag (framing/overrun); cleared by the next LOAD_CMD or by reset
// BEHAVIOUR
//  Reset values: mem_we_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, core_rst_o=1, busy_o=0, done_o=0, err_o=0.
//  Reset is honoured at any time, including mid-byte or mid-write: all state returns to the reset values.
//  RX front end:
//   - rx_i passes through a 2-flop synchroniser, reset to 1.
//   - A falling edge while the front end is idle starts the bit counter.
//   - At BAUD_DIV/2 the start bit is re-checked; if it reads high it is a glitch, no byte is produced, and the front end returns to idle.
//   - Bits d0..d7 are then sampled every BAUD_DIV clocks, followed by the stop bit.
//   - Stop=1: rx_byte_valid pulses for 1 cycle, aligned with the stop-bit sample.
//   - Stop=0: framing error. No byte is produced, err_o is set, the loader FSM goes to IDLE, and the front end waits for the line to return high.
//  Loader FSM states: IDLE, SIZE, DATA, WRITE, DONE.
//   - IDLE: a byte equal to LOAD_CMD moves to SIZE and does all of the following:
//     core_rst_o=1, err_o=0, address=BASE_ADDR, byte counter=0, word shift register=0.
//     Any other byte is ignored; core_rst_o is unchanged.
//   - SIZE: the next byte is latched as remaining count N.
//     N=0: go to DONE. Otherwise go to DATA.
//   - DATA: each byte is placed at lane [8*k +: 8], k = byte index 0..3, and N is decremented.
//     When k==3 or N reaches 0, go to WRITE. In a partial final word the unfilled lanes are 0.
//   - WRITE: the cycle after entry, mem_we_o=1 with a stable address and data.
//     On the mem_ack_i cycle: mem_we_o drops and the address increments, wrapping modulo 2^ADDR_W.
//     Then: N==0 goes to DONE; otherwise it goes to DATA with k=0 and lanes cleared.
//     Overrun: if a byte arrives while in WRITE, err_o=1, the write is still completed, and the FSM then goes to IDLE without releasing core_rst_o.
//   - DONE: done_o=1 for 1 cycle, core_rst_o=0 on the same cycle, then IDLE.
//  A later LOAD_CMD re-asserts core_rst_o and reloads from BASE_ADDR.
//  Latency: mem_we_o rises 2 cycles after the rx_byte_valid of the byte that completes the word.
//  mem_ack_i outside WRITE is ignored.
// TESTING
//  1. Send 77,0C, then 93 02 10 04 23 06 50 00 6F 00 00 00 at BAUD_DIV.
//     Required: 3 writes, addr 0/1/2, data 04100293 / 00500623 / 0000006F.
//     Required: a single done_o pulse; core_rst_o 1->0 after the 3rd ack; err_o=0.
//  2. Send 55, then 77,00.
//     Required: the 55 is ignored with no write; done_o pulses after the size byte; core_rst_o falls; no mem_we_o.
//  3. Send 77,05 then 11 22 33 44 AA.
//     Required: writes 44332211 at addr 0 and 000000AA at addr 1.
//  4. Framing error: send 77,08 then a data byte with stop=0.
//     Required: err_o=1; FSM returns to IDLE; core_rst_o stays 1; a following valid 77,00 sequence clears err_o and releases the core.
//  5. Glitch: drive rx_i low for BAUD_DIV/4 clocks.
//     Required: no byte, no state change. Separately, hold mem_ack_i low for >10*BAUD_DIV clocks during WRITE while bytes keep arriving.
//     Required: err_o=1 (overrun) and core_rst_o stays 1.
//  6. Assert wb_rst_i mid-way through byte 6 of test 1, then release it and repeat test 1.
//     Required: all outputs are at reset values during reset; the repeated test 1 passes fully.

Source files
------------

// File: rtl/leaf_uart_boot_loader.sv
// leaf_uart_boot_loader: UART boot stream receiver that writes a program into Leaf instruction memory
module leaf_uart_boot_loader #(
  parameter int BAUD_DIV = 434,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0] LOAD_CMD = 8'h77
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_o,
  input  logic              mem_ack_i,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_t;
  typedef enum logic [2:0] {IDLE, SIZE, DATA, WRITE, DONE} st_t;
  rx_t rs, rs_n;
  st_t st, st_n;
  logic s1, rx_s, rx_d, rx_v, rx_fe, we_n, cr, cr_n, er_n, ov, ov_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitn, bit_n;
  logic [7:0] sh, sh_n, n, n_n;
  logic [1:0] k, k_n;
  logic [31:0] wd_n;
  logic [ADDR_W-1:0] ad_n;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      {s1, rx_s, rx_d} <= 3'b111;
      rs <= R_IDLE;
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      st <= IDLE;
      n <= '0;
      k <= '0;
      mem_wdata_o <= '0;
      mem_addr_o <= BASE_ADDR;
      mem_we_o <= 1'b0;
      cr <= 1'b1;
      err_o <= 1'b0;
      ov <= 1'b0;
    end else begin
      {s1, rx_s, rx_d} <= {rx_i, s1, rx_s};
      rs <= rs_n;
      cnt <= cnt_n;
      bitn <= bit_n;
      sh <= sh_n;
      st <= st_n;
      n <= n_n;
      k <= k_n;
      mem_wdata_o <= wd_n;
      mem_addr_o <= ad_n;
      mem_we_o <= we_n;
      cr <= cr_n;
      err_o <= er_n;
      ov <= ov_n;
    end
  always_comb begin
    rs_n = rs;
    cnt_n = cnt + 1'b1;
    bit_n = bitn;
    sh_n = sh;
    rx_v = 1'b0;
    rx_fe = 1'b0;
    case (rs)
      R_IDLE: begin
        cnt_n = '0;
        rs_n = (rx_d & ~rx_s) ? R_START : R_IDLE;
      end
      R_START: if (cnt == CW'(BAUD_DIV / 2 - 1)) begin
        cnt_n = '0;
        bit_n = '0;
        rs_n = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == CW'(BAUD_DIV - 1)) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        bit_n = bitn + 1'b1;
        rs_n = (bitn == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt == CW'(BAUD_DIV - 1)) begin
        rx_v = rx_s;
        rx_fe = ~rx_s;
        rs_n = rx_s ? R_IDLE : R_WAIT;
      end
      default: begin
        cnt_n = '0;
        rs_n = rx_s ? R_IDLE : R_WAIT;
      end
    endcase
  end
  always_comb begin
    st_n = st;
    n_n = n;
    k_n = k;
    wd_n = mem_wdata_o;
    ad_n = mem_addr_o;
    we_n = mem_we_o;
    cr_n = cr;
    er_n = err_o;
    ov_n = ov;
    if (rx_fe) begin
      er_n = 1'b1;
      we_n = 1'b0;
      st_n = IDLE;
    end else case (st)
      IDLE: if (rx_v && sh == LOAD_CMD) begin
        st_n = SIZE;
        cr_n = 1'b1;
        er_n = 1'b0;
        ov_n = 1'b0;
        ad_n = BASE_ADDR;
        k_n = '0;
        wd_n = '0;
      end
      SIZE: if (rx_v) begin
        n_n = sh;
        st_n = (sh == 8'd0) ? DONE : DATA;
      end
      DATA: if (rx_v) begin
        wd_n[{k, 3'b000} +: 8] = sh;
        n_n = n - 1'b1;
        k_n = k + 1'b1;
        st_n = (k == 2'd3 || n == 8'd1) ? WRITE : DATA;
      end
      WRITE: begin
        we_n = ~(mem_we_o & mem_ack_i);
        er_n = err_o | rx_v;
        ov_n = ov | rx_v;
        if (mem_we_o & mem_ack_i) begin
          ad_n = mem_addr_o + 1'b1;
          k_n = '0;
          wd_n = '0;
          st_n = (ov | rx_v) ? IDLE : (n == 8'd0) ? DONE : DATA;
        end
      end
      DONE: begin
        cr_n = 1'b0;
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
  // the core is released combinationally so done_o and the falling reset share a cycle
  assign core_rst_o = cr & (st != DONE);
  assign done_o = st == DONE;
  assign busy_o = st == SIZE || st == DATA || st == WRITE;
endmodule
